// File: rtl/alu_exec_unit.sv
// 8-bit execute stage: single-cycle logic/add ops, iterative shifts and shift-add multiply.
// Result and condition flags are registered and announced with a one-cycle done pulse.
module alu_exec_unit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MUL_STEPS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int unsigned CW = $clog2(MUL_STEPS + 1);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpSub   = 3'b001,
        OpAnd   = 3'b010,
        OpOr    = 3'b011,
        OpShl   = 3'b100,
        OpShr   = 3'b101,
        OpMul   = 3'b110,
        OpPassa = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    // Datapath helpers shared by the next-state logic
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [AW-1:0]    acc_sum;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;

    // Completion bus: when complete is set the registered outputs take these values
    logic             complete;
    logic [WIDTH-1:0] res_new;
    logic             c_new;
    logic             v_new;

    assign is_sub  = (op == OpSub);
    assign b_eff   = is_sub ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {AW{1'b0}});
    assign shl_val = {shreg_q[WIDTH-2:0], 1'b0};
    assign shr_val = {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        complete = 1'b0;
        res_new  = '0;
        c_new    = 1'b0;
        v_new    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    unique case (op)
                        OpAdd, OpSub: begin
                            complete = 1'b1;
                            res_new  = sum[WIDTH-1:0];
                            c_new    = sum[WIDTH];
                            v_new    = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                       (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OpAnd: begin
                            complete = 1'b1;
                            res_new  = a & b;
                        end
                        OpOr: begin
                            complete = 1'b1;
                            res_new  = a | b;
                        end
                        OpShl, OpShr: begin
                            // Zero-count shifts finish immediately with the operand unchanged
                            if (b[2:0] == 3'd0) begin
                                complete = 1'b1;
                                res_new  = a;
                            end else begin
                                state_d = StRun;
                                op_d    = op_e'(op);
                                shreg_d = a;
                                cnt_d   = CW'(b[2:0]);
                            end
                        end
                        OpMul: begin
                            state_d  = StRun;
                            op_d     = OpMul;
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            mplier_d = b;
                            cnt_d    = CW'(MUL_STEPS);
                        end
                        OpPassa: begin
                            complete = 1'b1;
                            res_new  = a;
                        end
                        default: ;
                    endcase
                end
            end

            StRun: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OpMul) begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CW'(1)) begin
                        complete = 1'b1;
                        res_new  = acc_sum[WIDTH-1:0];
                        c_new    = |acc_sum[AW-1:WIDTH];
                        state_d  = StIdle;
                    end
                end else begin
                    shreg_d = (op_q == OpShl) ? shl_val : shr_val;
                    if (cnt_q == CW'(1)) begin
                        complete = 1'b1;
                        res_new  = shreg_d;
                        // Carry is the bit that fell off on this final step
                        c_new    = (op_q == OpShl) ? shreg_q[WIDTH-1] : shreg_q[0];
                        state_d  = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        done_d   = 1'b0;
        if (complete) begin
            result_d = res_new;
            z_d      = (res_new == '0);
            n_d      = res_new[WIDTH-1];
            c_d      = c_new;
            v_d      = v_new;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            cnt_q    <= '0;
            shreg_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = done_q;
    assign result = result_q;
    assign z      = z_q;
    assign n      = n_q;
    assign c      = c_q;
    assign v      = v_q;

endmodule
